lsu: RTL and testbench

- Load/store initiator between the pipeline MEM stage and the word-only data memory.
- Memory side: one 32-bit word per access; ignores addr[1:0]; writes whole words only.
- Loads: lsu selects and sign/zero-extends byte/half lanes from the returned word.
- Stores: word stores write directly; sb/sh use a two-cycle read-modify-write FSM.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu.sv | 125 ++++++++++++
 tb/tb_lsu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional misalignment checking is enabled with LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_t;

    localparam logic [2:0] MEM_CTRL_WORD = 3'b010;

    // Replace the addressed lane(s) of the old word; size 11 acts as word.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = old;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] off,
        input logic [1:0] size
    );
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select and sign/zero extension of a raw memory word.
// Combinational; shared by the lsu and by verification models.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        u_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word_i[{off_i, 3'b000} +: 8];
        lane_h = word_i[{off_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: data_o = {{24{~u_i & lane_b[7]}}, lane_b};
            SZ_HALF: data_o = {{16{~u_i & lane_h[15]}}, lane_h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit for a word-only data memory; sb/sh use read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [2:0]        req_ctrl,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wd,
    output logic [2:0]        mem_ctrl,
    input  logic [XLEN-1:0]   mem_rd
);

    lsu_state_t        state_q, state_d;
    logic [XLEN-1:0]   wbuf_q, wbuf_d;
    logic [ADDR_W-1:0] abuf_q, abuf_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              mis;
    logic              we_raw;
    logic [1:0]        size;
    logic [1:0]        off;
    logic [ADDR_W-1:0] aligned;
    logic [XLEN-1:0]   ld_data;

    assign size    = req_ctrl[1:0];
    assign off     = req_addr[1:0];
    assign aligned = {req_addr[ADDR_W-1:2], 2'b00};
    assign accept  = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = misaligned(off, size);
`else
    assign mis = 1'b0;
`endif

    load_align u_align (
        .word_i (mem_rd),
        .off_i  (off),
        .size_i (size),
        .u_i    (req_ctrl[2]),
        .data_o (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        wbuf_d      = wbuf_q;
        abuf_d      = abuf_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        mem_a       = aligned;
        mem_wd      = req_wdata;
        we_raw      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_we || mis) begin
                        // Misaligned stores answer like loads so the error surfaces.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = mis;
                        rsp_rdata_d = mis ? '0 : ld_data;
                    end else if (size[1]) begin
                        we_raw = 1'b1;
                    end else begin
                        wbuf_d  = merge_store(mem_rd, req_wdata, off, size);
                        abuf_d  = aligned;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_a   = abuf_q;
                mem_wd  = wbuf_q;
                we_raw  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wbuf_q      <= '0;
            abuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbuf_q      <= wbuf_d;
            abuf_q      <= abuf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_we    = we_raw & ~reset;
    assign mem_ctrl  = MEM_CTRL_WORD;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == WRITE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a 16-word behavioural memory.
// Misalignment vectors follow LSU_MISALIGN_CHECK_EN.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    end

    lsu dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_ctrl  (mem_ctrl),
        .mem_rd    (mem_rd)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a,
                         input logic [2:0] c, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_ctrl  = c;
        req_wdata = wd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [2:0] c, input logic [31:0] exp);
        drive(1'b0, a, c, 32'h0);
        tick();
        check({tag, ".v"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".d"}, rsp_rdata, exp);
        check({tag, ".e"}, {31'b0, rsp_err}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899AABB;
        mem[1] = 32'h11223344;
        reset = 1'b1;
        idle();
        req_addr  = 32'h0;
        req_ctrl  = 3'b010;
        req_wdata = 32'h0;
        tick();
        // A word store during reset must not reach memory.
        drive(1'b1, 32'hC, 3'b010, 32'h5555AAAA);
        #1;
        check("rst.we", {31'b0, mem_we}, 32'd0);
        tick();
        idle();
        check("rst.rv", {31'b0, rsp_valid}, 32'd0);
        check("rst.rd", rsp_rdata, 32'h0);
        check("rst.err", {31'b0, rsp_err}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.rdy", {31'b0, req_ready}, 32'd1);
        check("mem_ctrl", {29'b0, mem_ctrl}, 32'h2);
        reset = 1'b0;
        tick();
        check("rst.mem", mem[3], 32'h0);

        // Back-to-back loads.
        load("lb3", 32'h3, 3'b000, 32'hFFFFFF88);
        load("lbu3", 32'h3, 3'b100, 32'h00000088);
        load("lh2", 32'h2, 3'b001, 32'hFFFF8899);
        load("lh0", 32'h0, 3'b001, 32'hFFFFAABB);
        load("lhu2", 32'h2, 3'b101, 32'h00008899);
        load("lb0", 32'h0, 3'b000, 32'hFFFFFFBB);
        load("lbu1", 32'h1, 3'b100, 32'h000000AA);
        load("lw0", 32'h0, 3'b010, 32'h8899AABB);
        idle();
        tick();
        check("idle.rv", {31'b0, rsp_valid}, 32'd0);

        // sb 0xEE to 0x5 via RMW.
        drive(1'b1, 32'h5, 3'b000, 32'hFFFFFFEE);
        #1;
        check("sb.c0we", {31'b0, mem_we}, 32'd0);
        check("sb.c0rdy", {31'b0, req_ready}, 32'd1);
        check("sb.c0a", mem_a, 32'h4);
        tick();
        check("sb.busy", {31'b0, busy}, 32'd1);
        check("sb.rdy", {31'b0, req_ready}, 32'd0);
        check("sb.we", {31'b0, mem_we}, 32'd1);
        check("sb.wd", mem_wd, 32'h1122EE44);
        check("sb.a", mem_a, 32'h4);
        tick();
        idle();
        check("sb.done", {31'b0, busy}, 32'd0);
        check("sb.rv", {31'b0, rsp_valid}, 32'd0);
        load("sb.lw", 32'h4, 3'b010, 32'h1122EE44);

        // sh 0x1234 to 0x2 of word 0.
        drive(1'b1, 32'h2, 3'b001, 32'hABCD1234);
        tick();
        check("sh.wd", mem_wd, 32'h1234AABB);
        tick();
        load("sh.lw", 32'h0, 3'b010, 32'h1234AABB);

        // sw writes in the acceptance cycle.
        drive(1'b1, 32'h8, 3'b010, 32'hDEADBEEF);
        #1;
        check("sw.we", {31'b0, mem_we}, 32'd1);
        check("sw.wd", mem_wd, 32'hDEADBEEF);
        check("sw.busy", {31'b0, busy}, 32'd0);
        tick();
        idle();
        check("sw.busy1", {31'b0, busy}, 32'd0);
        check("sw.rv", {31'b0, rsp_valid}, 32'd0);
        load("sw.lw", 32'h8, 3'b010, 32'hDEADBEEF);

        // Reset during WRITE drops the store.
        drive(1'b1, 32'h6, 3'b001, 32'h0000CAFE);
        tick();
        check("rw.busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw.we", {31'b0, mem_we}, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        check("rw.idle", {31'b0, busy}, 32'd0);
        check("rw.rdy", {31'b0, req_ready}, 32'd1);
        tick();
        load("rw.lw", 32'h4, 3'b010, 32'h1122EE44);

`ifdef LSU_MISALIGN_CHECK_EN
        drive(1'b0, 32'h2, 3'b010, 32'h0);
        tick();
        check("mis.lw.v", {31'b0, rsp_valid}, 32'd1);
        check("mis.lw.e", {31'b0, rsp_err}, 32'd1);
        check("mis.lw.d", rsp_rdata, 32'h0);
        drive(1'b1, 32'h1, 3'b001, 32'h0000BEEF);
        #1;
        check("mis.sh.we", {31'b0, mem_we}, 32'd0);
        tick();
        idle();
        check("mis.sh.v", {31'b0, rsp_valid}, 32'd1);
        check("mis.sh.e", {31'b0, rsp_err}, 32'd1);
        check("mis.sh.busy", {31'b0, busy}, 32'd0);
        #1;
        check("mis.sh.we1", {31'b0, mem_we}, 32'd0);
        tick();
        check("mis.sh.mem", mem[0], 32'h1234AABB);
`else
        load("trunc.lw", 32'h2, 3'b010, 32'h1234AABB);
        load("trunc.lh", 32'h3, 3'b001, 32'h00001234 | 32'h0);
`endif
        idle();
        tick();
        check("end.rv", {31'b0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
